// File: rtl/avg_frame_buffer.sv
// Ping-pong frame buffer between the averaging stage and the FFT input.
// The write side captures whole frames from a free-running source into one of
// two banks; the read side replays full banks over a valid/ready stream with
// a last-beat marker. A frame whose target bank is still occupied at its first
// sample is dropped in its entirety and the sticky overflow flag is raised.
module avg_frame_buffer #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 128,
    parameter int IDX_W     = 7
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    input  logic              i_data_ready,
    output logic              o_last,
    output logic              o_overflow,
    output logic [15:0]       o_frame_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Both banks live in one array; the bank number is the address MSB.
    logic [DATA_W-1:0] mem [0:2*FRAME_LEN-1];

    // Write-side state
    logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
    logic             wr_bank_reg, wr_bank_next;
    logic             drop_reg, drop_next;
    logic             overflow_reg, overflow_next;
    logic [1:0]       full_reg, full_next;

    // Read-side state
    state_t           state_reg, state_next;
    logic             rd_bank_reg, rd_bank_next;
    logic [IDX_W-1:0] rd_idx_reg, rd_idx_next;
    logic [15:0]      frame_cnt_reg, frame_cnt_next;
    logic [DATA_W-1:0] rd_data_reg;
    logic             rd_en;
    logic [IDX_W:0]   rd_addr;

    // Event decode
    logic       accept;
    logic       release_frame;
    logic       frame_start;
    logic       bank_busy;
    logic       start_drop;
    logic       wr_en;
    logic       wr_done;
    logic [1:0] release_hit;
    logic [1:0] fill_hit;

    assign accept        = (state_reg == ST_STREAM) && i_data_ready;
    assign release_frame = accept && (rd_idx_reg == LAST_IDX);

    // Per-bank events: a bank is freed by the final accepted beat of its frame
    // and filled by the write of its final sample. Both may occur in one cycle
    // on different banks.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank_evt
            assign release_hit[gi] = release_frame && (rd_bank_reg == 1'(gi));
            assign fill_hit[gi]    = wr_done && (wr_bank_reg == 1'(gi));
        end
    endgenerate

    // A bank being released this very cycle already counts as empty, so a
    // frame starting on it in the same cycle is kept.
    assign frame_start = i_data_valid && !drop_reg && (wr_idx_reg == '0);
    assign bank_busy   = full_reg[wr_bank_reg] && !release_hit[wr_bank_reg];
    assign start_drop  = frame_start && bank_busy;
    assign wr_en       = i_data_valid && !drop_reg && !start_drop;
    assign wr_done     = wr_en && (wr_idx_reg == LAST_IDX);

    // Sample write into the active bank.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[{wr_bank_reg, wr_idx_reg}] <= i_data;
        end
    end

    // Registered memory read; the register only loads when a new sample is
    // fetched, so it doubles as the stall-stable output holding register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    // Write index, bank selection, drop window and sticky overflow.
    always_comb begin
        wr_idx_next   = wr_idx_reg;
        wr_bank_next  = wr_bank_reg;
        drop_next     = drop_reg;
        overflow_next = overflow_reg;
        if (i_data_valid) begin
            // Dropped samples still advance the index to keep frame alignment.
            wr_idx_next = wr_idx_reg + IDX_ONE;
            if (start_drop) begin
                drop_next     = 1'b1;
                overflow_next = 1'b1;
            end
            if (drop_reg && (wr_idx_reg == LAST_IDX)) begin
                drop_next = 1'b0;
            end
            if (wr_done) begin
                wr_bank_next = ~wr_bank_reg;
            end
        end
    end

    // Bank occupancy: release first, then fill.
    always_comb begin
        full_next = (full_reg & ~release_hit) | fill_hit;
    end

    // Write-side and bank-status registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_idx_reg   <= '0;
            wr_bank_reg  <= 1'b0;
            drop_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            full_reg     <= '0;
        end else begin
            wr_idx_reg   <= wr_idx_next;
            wr_bank_reg  <= wr_bank_next;
            drop_reg     <= drop_next;
            overflow_reg <= overflow_next;
            full_reg     <= full_next;
        end
    end

    // Read FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Read FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (full_reg[rd_bank_reg]) begin
                    state_next = ST_PRIME;
                end
            end
            ST_PRIME: begin
                state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (release_frame) begin
                    state_next = full_reg[~rd_bank_reg] ? ST_PRIME : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        o_data_valid = (state_reg == ST_STREAM);
        o_last       = (state_reg == ST_STREAM) && (rd_idx_reg == LAST_IDX);
    end

    // Read addressing: PRIME fetches sample 0; in STREAM each accepted
    // non-final beat fetches the following sample in the same cycle, which
    // sustains one beat per clock while the consumer stays ready.
    always_comb begin
        rd_en          = 1'b0;
        rd_addr        = {rd_bank_reg, rd_idx_reg};
        rd_idx_next    = rd_idx_reg;
        rd_bank_next   = rd_bank_reg;
        frame_cnt_next = frame_cnt_reg;
        case (state_reg)
            ST_PRIME: begin
                rd_en   = 1'b1;
                rd_addr = {rd_bank_reg, rd_idx_reg};
            end
            ST_STREAM: begin
                if (accept) begin
                    if (release_frame) begin
                        rd_idx_next    = '0;
                        rd_bank_next   = ~rd_bank_reg;
                        frame_cnt_next = frame_cnt_reg + 16'd1;
                    end else begin
                        rd_en       = 1'b1;
                        rd_addr     = {rd_bank_reg, rd_idx_reg + IDX_ONE};
                        rd_idx_next = rd_idx_reg + IDX_ONE;
                    end
                end
            end
            default: begin
                rd_en = 1'b0;
            end
        endcase
    end

    // Read-side datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_bank_reg   <= 1'b0;
            rd_idx_reg    <= '0;
            frame_cnt_reg <= '0;
        end else begin
            rd_bank_reg   <= rd_bank_next;
            rd_idx_reg    <= rd_idx_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    assign o_data      = rd_data_reg;
    assign o_overflow  = overflow_reg;
    assign o_frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_avg_frame_buffer.sv
// Bench for avg_frame_buffer: expected beats are queued as frames are driven
// and compared against the beats the consumer side actually accepts.
module tb_avg_frame_buffer;

    localparam int DATA_W    = 32;
    localparam int FRAME_LEN = 128;
    localparam int IDX_W     = 7;
    localparam int OBS_MAX   = 2048;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              ready;
    logic              last;
    logic              overflow;
    logic [15:0]       frame_cnt;

    avg_frame_buffer #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .IDX_W     (IDX_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data       (din),
        .i_data_valid (din_valid),
        .o_data       (dout),
        .o_data_valid (dout_valid),
        .i_data_ready (ready),
        .o_last       (last),
        .o_overflow   (overflow),
        .o_frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    // Observed accepted beats, written only by the monitor.
    logic [DATA_W-1:0] obs_data [0:OBS_MAX-1];
    logic              obs_last [0:OBS_MAX-1];
    int                obs_cyc  [0:OBS_MAX-1];
    int                obs_wr = 0;
    int                obs_rd = 0;
    int                stall_viol = 0;
    logic              prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic              prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records each beat that will be accepted at the next edge and
    // counts any change of a stalled beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold && (!dout_valid || dout !== prev_data || last !== prev_last))
                stall_viol <= stall_viol + 1;
            if (dout_valid && ready && obs_wr < OBS_MAX) begin
                obs_data[obs_wr] <= dout;
                obs_last[obs_wr] <= last;
                obs_cyc[obs_wr]  <= cyc;
                obs_wr           <= obs_wr + 1;
            end
            prev_hold <= dout_valid && !ready;
            prev_data <= dout;
            prev_last <= last;
        end else begin
            prev_hold <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        ready     = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] base, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = base + DATA_W'(i);
            b.l = (i == FRAME_LEN - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_samples(input logic [DATA_W-1:0] base, input int from,
                                 input int to, input int idle_pct);
        for (int i = from; i <= to; i++) begin
            while (int'($urandom_range(0, 99)) < idle_pct) begin
                din_valid = 1'b0;
                tick();
            end
            din       = base + DATA_W'(i);
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int budget, output bit ok);
        for (int c = 0; c < budget && obs_wr < target; c++) tick();
        ok = (obs_wr >= target);
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", dout_valid); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", dout); end
        checks++; if (last !== 1'b0) begin errors++; $display("FAIL rst_last: got %0b expected 0", last); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0b expected 0", overflow); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int start, gaps;
        bit ok;
        beat_t e;
        apply_reset();
        ready = 1'b1;
        start = obs_wr;
        push_frame(32'd0, FRAME_LEN);
        drive_samples(32'd0, 0, FRAME_LEN - 1, 0);
        @(negedge clk);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_n1: got %0b expected 0", dout_valid); end
        @(negedge clk);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_n2: got %0b expected 0", dout_valid); end
        @(negedge clk);
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL t1_valid_rise: got %0b expected 1", dout_valid); end
        wait_beats(start + FRAME_LEN, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t1_timeout: got %0d beats expected %0d", obs_wr - start, FRAME_LEN); end
        repeat (10) tick();
        gaps = 0;
        for (int k = start + 1; k < obs_wr; k++) if (obs_cyc[k] != obs_cyc[k-1] + 1) gaps++;
        checks++; if (gaps != 0) begin errors++; $display("FAIL t1_consecutive: got %0d gaps expected 0", gaps); end
        checks++; if (obs_wr - start != FRAME_LEN) begin errors++; $display("FAIL t1_count: got %0d expected %0d", obs_wr - start, FRAME_LEN); end
        while (obs_rd < obs_wr) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL t1_extra: got %h expected none", obs_data[obs_rd]); end
            else begin
                e = exp_q.pop_front();
                if (obs_data[obs_rd] !== e.d || obs_last[obs_rd] !== e.l) begin errors++; $display("FAIL t1_beat: got %h/%0b expected %h/%0b", obs_data[obs_rd], obs_last[obs_rd], e.d, e.l); end
            end
            obs_rd++;
        end
        @(negedge clk);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL t1_frame_cnt: got %0d expected 1", frame_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t1_overflow: got %0b expected 0", overflow); end
        $display("test_basic done: %0d beats", obs_wr - start);
    endtask

    task automatic test_ready_toggle();
        int start, viol0;
        bit ok;
        beat_t e;
        apply_reset();
        start = obs_wr;
        viol0 = stall_viol;
        push_frame(32'd0, FRAME_LEN);
        drive_samples(32'd0, 0, FRAME_LEN - 1, 0);
        for (int c = 0; c < 800 && obs_wr < start + FRAME_LEN; c++) begin
            ready = ~ready;
            tick();
        end
        ok = (obs_wr >= start + FRAME_LEN);
        checks++; if (!ok) begin errors++; $display("FAIL t2_timeout: got %0d beats expected %0d", obs_wr - start, FRAME_LEN); end
        ready = 1'b0;
        repeat (10) tick();
        checks++; if (stall_viol != viol0) begin errors++; $display("FAIL t2_stable: got %0d changes expected 0", stall_viol - viol0); end
        checks++; if (obs_wr - start != FRAME_LEN) begin errors++; $display("FAIL t2_count: got %0d expected %0d", obs_wr - start, FRAME_LEN); end
        while (obs_rd < obs_wr) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL t2_extra: got %h expected none", obs_data[obs_rd]); end
            else begin
                e = exp_q.pop_front();
                if (obs_data[obs_rd] !== e.d || obs_last[obs_rd] !== e.l) begin errors++; $display("FAIL t2_beat: got %h/%0b expected %h/%0b", obs_data[obs_rd], obs_last[obs_rd], e.d, e.l); end
            end
            obs_rd++;
        end
        @(negedge clk);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL t2_frame_cnt: got %0d expected 1", frame_cnt); end
        $display("test_ready_toggle done: %0d beats", obs_wr - start);
    endtask

    task automatic test_overflow();
        int start;
        bit ok;
        beat_t e;
        apply_reset();
        start = obs_wr;
        push_frame(32'hA000_0000, FRAME_LEN);
        push_frame(32'hB000_0000, FRAME_LEN);
        drive_samples(32'hA000_0000, 0, FRAME_LEN - 1, 0);
        drive_samples(32'hB000_0000, 0, FRAME_LEN - 1, 0);
        din       = 32'hC000_0000;
        din_valid = 1'b1;
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t3_ovf_before: got %0b expected 0", overflow); end
        tick();
        @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t3_ovf_after: got %0b expected 1", overflow); end
        drive_samples(32'hC000_0000, 1, FRAME_LEN - 1, 0);
        ready = 1'b1;
        wait_beats(start + 2 * FRAME_LEN, 800, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t3_timeout_ab: got %0d beats expected %0d", obs_wr - start, 2 * FRAME_LEN); end
        repeat (10) tick();
        @(negedge clk);
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL t3_frame_cnt_ab: got %0d expected 2", frame_cnt); end
        checks++; if (obs_wr - start != 2 * FRAME_LEN) begin errors++; $display("FAIL t3_count_ab: got %0d expected %0d", obs_wr - start, 2 * FRAME_LEN); end
        push_frame(32'hD000_0000, FRAME_LEN);
        drive_samples(32'hD000_0000, 0, FRAME_LEN - 1, 0);
        wait_beats(start + 3 * FRAME_LEN, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t3_timeout_d: got %0d beats expected %0d", obs_wr - start, 3 * FRAME_LEN); end
        repeat (10) tick();
        checks++; if (obs_wr - start != 3 * FRAME_LEN) begin errors++; $display("FAIL t3_count_d: got %0d expected %0d", obs_wr - start, 3 * FRAME_LEN); end
        while (obs_rd < obs_wr) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL t3_extra: got %h expected none", obs_data[obs_rd]); end
            else begin
                e = exp_q.pop_front();
                if (obs_data[obs_rd] !== e.d || obs_last[obs_rd] !== e.l) begin errors++; $display("FAIL t3_beat: got %h/%0b expected %h/%0b", obs_data[obs_rd], obs_last[obs_rd], e.d, e.l); end
            end
            obs_rd++;
        end
        @(negedge clk);
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL t3_frame_cnt_d: got %0d expected 3", frame_cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t3_ovf_sticky: got %0b expected 1", overflow); end
        $display("test_overflow done: %0d beats", obs_wr - start);
    endtask

    task automatic test_gaps();
        int start;
        bit ok;
        beat_t e;
        apply_reset();
        ready = 1'b1;
        start = obs_wr;
        push_frame(32'd0, FRAME_LEN);
        drive_samples(32'd0, 0, FRAME_LEN - 1, 30);
        wait_beats(start + FRAME_LEN, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t4_timeout: got %0d beats expected %0d", obs_wr - start, FRAME_LEN); end
        repeat (10) tick();
        checks++; if (obs_wr - start != FRAME_LEN) begin errors++; $display("FAIL t4_count: got %0d expected %0d", obs_wr - start, FRAME_LEN); end
        while (obs_rd < obs_wr) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL t4_extra: got %h expected none", obs_data[obs_rd]); end
            else begin
                e = exp_q.pop_front();
                if (obs_data[obs_rd] !== e.d || obs_last[obs_rd] !== e.l) begin errors++; $display("FAIL t4_beat: got %h/%0b expected %h/%0b", obs_data[obs_rd], obs_last[obs_rd], e.d, e.l); end
            end
            obs_rd++;
        end
        @(negedge clk);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL t4_frame_cnt: got %0d expected 1", frame_cnt); end
        $display("test_gaps done: %0d beats", obs_wr - start);
    endtask

    task automatic test_reset_midread();
        int start;
        bit ok;
        beat_t e;
        apply_reset();
        start = obs_wr;
        push_frame(32'h5000_0000, 60);
        drive_samples(32'h5000_0000, 0, FRAME_LEN - 1, 0);
        drive_samples(32'h6000_0000, 0, FRAME_LEN - 1, 0);
        ready = 1'b1;
        for (int c = 0; c < 400 && obs_wr - start < 60; c++) tick();
        checks++; if (obs_wr - start != 60) begin errors++; $display("FAIL t5_pre_count: got %0d expected 60", obs_wr - start); end
        rst_n = 1'b0;
        ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({dout, dout_valid, last, overflow, frame_cnt} !== '0) begin
                errors++;
                $display("FAIL t5_idle: got data=%h valid=%0b last=%0b ovf=%0b cnt=%0d expected all 0", dout, dout_valid, last, overflow, frame_cnt);
            end
        end
        checks++; if (obs_wr - start != 60) begin errors++; $display("FAIL t5_post_count: got %0d expected 60", obs_wr - start); end
        push_frame(32'hE000_0000, FRAME_LEN);
        tick();
        drive_samples(32'hE000_0000, 0, FRAME_LEN - 1, 0);
        wait_beats(start + 60 + FRAME_LEN, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t5_timeout: got %0d beats expected %0d", obs_wr - start, 60 + FRAME_LEN); end
        repeat (10) tick();
        checks++; if (obs_wr - start != 60 + FRAME_LEN) begin errors++; $display("FAIL t5_count: got %0d expected %0d", obs_wr - start, 60 + FRAME_LEN); end
        while (obs_rd < obs_wr) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL t5_extra: got %h expected none", obs_data[obs_rd]); end
            else begin
                e = exp_q.pop_front();
                if (obs_data[obs_rd] !== e.d || obs_last[obs_rd] !== e.l) begin errors++; $display("FAIL t5_beat: got %h/%0b expected %h/%0b", obs_data[obs_rd], obs_last[obs_rd], e.d, e.l); end
            end
            obs_rd++;
        end
        @(negedge clk);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL t5_frame_cnt: got %0d expected 1", frame_cnt); end
        $display("test_reset_midread done: %0d beats", obs_wr - start);
    endtask

    task automatic test_back_to_back();
        int start;
        bit ok;
        beat_t e;
        apply_reset();
        ready = 1'b1;
        start = obs_wr;
        push_frame(32'h1000_0000, FRAME_LEN);
        push_frame(32'h2000_0000, FRAME_LEN);
        push_frame(32'h3000_0000, FRAME_LEN);
        drive_samples(32'h1000_0000, 0, FRAME_LEN - 1, 0);
        drive_samples(32'h2000_0000, 0, FRAME_LEN - 1, 0);
        tick();
        din       = 32'h3000_0000;
        din_valid = 1'b1;
        @(negedge clk);
        checks++; if (!(dout_valid === 1'b1 && last === 1'b1)) begin errors++; $display("FAIL t6_coincide: got valid=%0b last=%0b expected 1/1", dout_valid, last); end
        tick();
        drive_samples(32'h3000_0000, 1, FRAME_LEN - 1, 0);
        wait_beats(start + 3 * FRAME_LEN, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t6_timeout: got %0d beats expected %0d", obs_wr - start, 3 * FRAME_LEN); end
        repeat (10) tick();
        checks++; if (obs_wr - start != 3 * FRAME_LEN) begin errors++; $display("FAIL t6_count: got %0d expected %0d", obs_wr - start, 3 * FRAME_LEN); end
        while (obs_rd < obs_wr) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL t6_extra: got %h expected none", obs_data[obs_rd]); end
            else begin
                e = exp_q.pop_front();
                if (obs_data[obs_rd] !== e.d || obs_last[obs_rd] !== e.l) begin errors++; $display("FAIL t6_beat: got %h/%0b expected %h/%0b", obs_data[obs_rd], obs_last[obs_rd], e.d, e.l); end
            end
            obs_rd++;
        end
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t6_overflow: got %0b expected 0", overflow); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL t6_frame_cnt: got %0d expected 3", frame_cnt); end
        $display("test_back_to_back done: %0d beats", obs_wr - start);
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        ready     = 1'b0;
        test_reset();
        test_basic();
        test_ready_toggle();
        test_overflow();
        test_gaps();
        test_reset_midread();
        test_back_to_back();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
